// File: rtl/simple_stim_chk_pkg.sv
// Shared types and constants for the simple_stim_chk stimulus/checker.
// The LFSR step function lives here so the generator and any future users agree on the sequence.
package simple_stim_chk_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_INIT  = 3'd1,
    S_RUN   = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  localparam int unsigned INIT_CYCLES  = 2;
  localparam logic [15:0] LFSR_TAPS    = 16'hB400;
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

  // Mask bit 15 is tap 16. Tap 16 is the bit about to be shifted out (bit 0),
  // so the mask is mirrored before it is applied to the state.
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    logic [15:0] rev;
    rev = {<<{LFSR_TAPS}};
    return {^(s & rev), s[15:1]};
  endfunction

endpackage

// File: rtl/simple_stim_chk_lfsr.sv
// 16-bit Fibonacci LFSR that shifts toward bit 0, with synchronous load and advance.
// A zero seed is replaced by 16'h0001 so the register can never lock up.
module simple_stim_chk_lfsr
  import simple_stim_chk_pkg::*;
#(
  parameter logic [15:0] SEED = DEFAULT_SEED
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic       advance,
  output logic [1:0] bits
);

  localparam logic [15:0] LOAD_VAL = (SEED == 16'h0000) ? 16'h0001 : SEED;

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (load) begin
      lfsr_d = LOAD_VAL;
    end else if (advance) begin
      lfsr_d = lfsr_next(lfsr_q);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lfsr_q <= LOAD_VAL;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign bits = lfsr_q[1:0];

endmodule

// File: rtl/simple_stim_chk.sv
// Stimulus generator and cycle-accurate checker for the 'simple' benchmark (NAND/NOR/DFF loop).
// Define SIMPLE_STIM_CHK_CAPTURE_EN to add the first_err_idx / first_err_exp capture outputs.
module simple_stim_chk
  import simple_stim_chk_pkg::*;
#(
  parameter int unsigned NUM_VECTORS = 256,
  parameter logic [15:0] LFSR_SEED   = DEFAULT_SEED,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             tau2015_clk,
  input  logic             tau2015_rst_n,
  input  logic             start,
  output logic             inp1,
  output logic             inp2,
  input  logic             dut_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] vec_cnt,
`ifdef SIMPLE_STIM_CHK_CAPTURE_EN
  output logic [CNT_W-1:0] first_err_idx,
  output logic             first_err_exp,
`endif
  output logic [2:0]       dbg_state
);

  localparam int unsigned RUN_W = $clog2(NUM_VECTORS + 1);
  localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(NUM_VECTORS);

  // start is a level request with no ready: it is acted on only in IDLE or DONE
  // (busy low); while busy is high it is ignored, never queued.
  state_e           state_q, state_d;
  logic [1:0]       init_cnt_q, init_cnt_d;
  logic [RUN_W-1:0] run_cnt_q, run_cnt_d;
  logic             inp1_q, inp1_d;
  logic             inp2_q, inp2_d;
  logic             m_q, m_d;
  logic             pass_q, pass_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic [CNT_W-1:0] vec_q, vec_d;
  logic             lfsr_load;
  logic             lfsr_adv;
  logic [1:0]       lfsr_bits;
  logic             cmp_en;
`ifdef SIMPLE_STIM_CHK_CAPTURE_EN
  logic [CNT_W-1:0] cmp_idx_q, cmp_idx_d;
  logic             cap_vld_q, cap_vld_d;
  logic [CNT_W-1:0] first_idx_q, first_idx_d;
  logic             first_exp_q, first_exp_d;
`endif

  simple_stim_chk_lfsr #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk     (tau2015_clk),
    .rst_n   (tau2015_rst_n),
    .load    (lfsr_load),
    .advance (lfsr_adv),
    .bits    (lfsr_bits)
  );

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    run_cnt_d  = run_cnt_q;
    inp1_d     = inp1_q;
    inp2_d     = inp2_q;
    m_d        = m_q;
    pass_d     = pass_q;
    err_d      = err_q;
    vec_d      = vec_q;
    lfsr_load  = 1'b0;
    lfsr_adv   = 1'b0;
    cmp_en     = 1'b0;
`ifdef SIMPLE_STIM_CHK_CAPTURE_EN
    cmp_idx_d   = cmp_idx_q;
    cap_vld_d   = cap_vld_q;
    first_idx_d = first_idx_q;
    first_exp_d = first_exp_q;
`endif

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d    = S_INIT;
          init_cnt_d = '0;
          run_cnt_d  = '0;
          inp1_d     = 1'b0;
          inp2_d     = 1'b0;
          m_d        = 1'b0;
          pass_d     = 1'b0;
          err_d      = '0;
          vec_d      = '0;
          lfsr_load  = 1'b1;
`ifdef SIMPLE_STIM_CHK_CAPTURE_EN
          cmp_idx_d   = '0;
          cap_vld_d   = 1'b0;
          first_idx_d = '0;
          first_exp_d = 1'b0;
`endif
        end
      end
      S_INIT, S_RUN: begin
        m_d    = inp1_q & inp2_q & ~m_q;
        cmp_en = (state_q == S_RUN);
        if (state_q == S_INIT && init_cnt_q != 2'(INIT_CYCLES - 1)) begin
          init_cnt_d = init_cnt_q + 2'd1;
        end else if (state_q == S_RUN && run_cnt_q == RUN_LAST) begin
          state_d = S_DRAIN;
          inp1_d  = 1'b0;
          inp2_d  = 1'b0;
        end else begin
          // The last INIT edge already presents vector 0, so RUN sees its effect on the first edge.
          state_d   = S_RUN;
          inp1_d    = lfsr_bits[0];
          inp2_d    = lfsr_bits[1];
          lfsr_adv  = 1'b1;
          run_cnt_d = run_cnt_q + RUN_W'(1);
          if (vec_q != '1) begin
            vec_d = vec_q + CNT_W'(1);
          end
        end
      end
      S_DRAIN: begin
        cmp_en  = 1'b1;
        state_d = S_DONE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (cmp_en && (dut_out != m_q)) begin
      if (err_q != '1) begin
        err_d = err_q + CNT_W'(1);
      end
`ifdef SIMPLE_STIM_CHK_CAPTURE_EN
      if (!cap_vld_q) begin
        cap_vld_d   = 1'b1;
        first_idx_d = cmp_idx_q;
        first_exp_d = m_q;
      end
`endif
    end
`ifdef SIMPLE_STIM_CHK_CAPTURE_EN
    if (cmp_en) begin
      cmp_idx_d = cmp_idx_q + CNT_W'(1);
    end
`endif

    if (state_q == S_DRAIN) begin
      pass_d = (err_d == '0);
    end
  end

  always_ff @(posedge tau2015_clk) begin
    if (!tau2015_rst_n) begin
      state_q    <= S_IDLE;
      init_cnt_q <= '0;
      run_cnt_q  <= '0;
      inp1_q     <= 1'b0;
      inp2_q     <= 1'b0;
      m_q        <= 1'b0;
      pass_q     <= 1'b0;
      err_q      <= '0;
      vec_q      <= '0;
`ifdef SIMPLE_STIM_CHK_CAPTURE_EN
      cmp_idx_q   <= '0;
      cap_vld_q   <= 1'b0;
      first_idx_q <= '0;
      first_exp_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      run_cnt_q  <= run_cnt_d;
      inp1_q     <= inp1_d;
      inp2_q     <= inp2_d;
      m_q        <= m_d;
      pass_q     <= pass_d;
      err_q      <= err_d;
      vec_q      <= vec_d;
`ifdef SIMPLE_STIM_CHK_CAPTURE_EN
      cmp_idx_q   <= cmp_idx_d;
      cap_vld_q   <= cap_vld_d;
      first_idx_q <= first_idx_d;
      first_exp_q <= first_exp_d;
`endif
    end
  end

  assign inp1      = inp1_q;
  assign inp2      = inp2_q;
  assign busy      = (state_q == S_INIT) || (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done      = (state_q == S_DONE);
  assign pass      = pass_q;
  assign err_cnt   = err_q;
  assign vec_cnt   = vec_q;
  assign dbg_state = state_q;
`ifdef SIMPLE_STIM_CHK_CAPTURE_EN
  assign first_err_idx = first_idx_q;
  assign first_err_exp = first_exp_q;
`endif

endmodule

// File: tb/tb_simple_stim_chk.sv
// Bench for simple_stim_chk: a behavioural 'simple' benchmark closes the loop, and an
// arithmetic LFSR/model predicts vectors, compare values and final counts.
`timescale 1ns/1ps
module tb_simple_stim_chk;

  localparam int N    = 16;
  localparam int CW   = 16;
  localparam int SN   = 32;
  localparam int SCW  = 4;
  localparam int SEED = 'hACE1;

  // clock / reset
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          start = 1'b0;
  logic          inp1, inp2, dut_out, busy, done, pass;
  logic [CW-1:0] err_cnt, vec_cnt;
  logic [2:0]    dbg_state;
`ifdef SIMPLE_STIM_CHK_CAPTURE_EN
  logic [CW-1:0] first_err_idx;
  logic          first_err_exp;
`endif

  logic           sat_start = 1'b0;
  logic           sat_inp1, sat_inp2, sat_dut_out, sat_busy, sat_done, sat_pass;
  logic [SCW-1:0] sat_err_cnt, sat_vec_cnt;
  logic [2:0]     sat_dbg_state;
`ifdef SIMPLE_STIM_CHK_CAPTURE_EN
  logic [SCW-1:0] sat_first_err_idx;
  logic           sat_first_err_exp;
`endif

  // behavioural 'simple' benchmarks: one flop, no reset
  logic f1     = 1'b0;
  logic sat_f1 = 1'b0;
  logic stuck  = 1'b0;
  always @(posedge clk) begin
    f1     <= inp1 & inp2 & ~f1;
    sat_f1 <= sat_inp1 & sat_inp2 & ~sat_f1;
  end
  assign dut_out     = stuck ? 1'b1 : f1;
  assign sat_dut_out = ~sat_f1;

  simple_stim_chk #(.NUM_VECTORS(N), .LFSR_SEED(16'hACE1), .CNT_W(CW)) u_dut (
    .tau2015_clk   (clk),
    .tau2015_rst_n (rst_n),
    .start         (start),
    .inp1          (inp1),
    .inp2          (inp2),
    .dut_out       (dut_out),
    .busy          (busy),
    .done          (done),
    .pass          (pass),
    .err_cnt       (err_cnt),
    .vec_cnt       (vec_cnt),
`ifdef SIMPLE_STIM_CHK_CAPTURE_EN
    .first_err_idx (first_err_idx),
    .first_err_exp (first_err_exp),
`endif
    .dbg_state     (dbg_state)
  );

  simple_stim_chk #(.NUM_VECTORS(SN), .LFSR_SEED(16'hACE1), .CNT_W(SCW)) u_sat (
    .tau2015_clk   (clk),
    .tau2015_rst_n (rst_n),
    .start         (sat_start),
    .inp1          (sat_inp1),
    .inp2          (sat_inp2),
    .dut_out       (sat_dut_out),
    .busy          (sat_busy),
    .done          (sat_done),
    .pass          (sat_pass),
    .err_cnt       (sat_err_cnt),
    .vec_cnt       (sat_vec_cnt),
`ifdef SIMPLE_STIM_CHK_CAPTURE_EN
    .first_err_idx (sat_first_err_idx),
    .first_err_exp (sat_first_err_exp),
`endif
    .dbg_state     (sat_dbg_state)
  );

  int total = 0;
  int bad   = 0;

  // scoreboard: expected {inp2,inp1} per RUN vector, and model value at each compare
  logic [1:0] exp_q[$];
  logic       m_exp[$];

  task automatic build_model(input int n);
    int   s;
    int   fb;
    logic m;
    exp_q.delete();
    m_exp.delete();
    s = SEED;
    m = 1'b0;
    for (int k = 0; k < n; k++) begin
      exp_q.push_back(s[1:0]);
      m_exp.push_back(m);
      m  = ((s % 2) == 1) && (((s / 2) % 2) == 1) && !m;
      fb = (s ^ (s >> 2) ^ (s >> 3) ^ (s >> 5)) & 1;
      s  = (s >> 1) | (fb << 15);
    end
    m_exp.push_back(m);
  endtask

  function automatic int count_zero_compares();
    int c = 0;
    foreach (m_exp[i]) if (m_exp[i] == 1'b0) c++;
    return c;
  endfunction

  // Driver: pulse start and walk every edge of a run, checking vectors and done timing.
  task automatic run_check(input bit pulse_mid);
    logic [1:0] vq[$];
    logic [1:0] exp_v;
    logic       exp_done;
    logic       exp_busy;
    vq = exp_q;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    total++;
    if (busy !== 1'b1 || done !== 1'b0 || err_cnt !== '0 || vec_cnt !== '0 || pass !== 1'b0) begin
      bad++;
      $display("FAIL start_clear busy=%b done=%b err=%0d vec=%0d pass=%b exp busy=1 done=0 err=0 vec=0 pass=0",
               busy, done, err_cnt, vec_cnt, pass);
    end
    for (int e = 1; e <= N + 3; e++) begin
      @(negedge clk);
      start = (pulse_mid && e == 5);
      exp_v    = (e >= 2 && e <= N + 1) ? vq.pop_front() : 2'b00;
      exp_done = (e == N + 3);
      exp_busy = (e <= N + 2);
      total++;
      if ({inp2, inp1} !== exp_v) begin
        bad++;
        $display("FAIL vector edge=%0d got=%b exp=%b", e, {inp2, inp1}, exp_v);
      end
      total++;
      if (done !== exp_done || busy !== exp_busy) begin
        bad++;
        $display("FAIL run_timing edge=%0d done=%b busy=%b exp done=%b busy=%b", e, done, busy, exp_done, exp_busy);
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b1; sat_start = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if (inp1 !== 1'b0 || inp2 !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || err_cnt !== '0 ||
        vec_cnt !== '0 || pass !== 1'b0) begin
      bad++;
      $display("FAIL reset_state inp=%b%b busy=%b done=%b err=%0d vec=%0d pass=%b exp all 0",
               inp2, inp1, busy, done, err_cnt, vec_cnt, pass);
    end
    start = 1'b0; sat_start = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || sat_busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_idle busy=%b sat_busy=%b exp 0 0", busy, sat_busy);
    end
  endtask

  task automatic check_final(input string name, input int exp_err, input logic exp_pass);
    total++;
    if (err_cnt !== CW'(exp_err) || pass !== exp_pass || vec_cnt !== CW'(N)) begin
      bad++;
      $display("FAIL %s err=%0d pass=%b vec=%0d exp err=%0d pass=%b vec=%0d",
               name, err_cnt, pass, vec_cnt, exp_err, exp_pass, N);
    end
  endtask

  task automatic test_golden();
    stuck = 1'b0;
    run_check(1'b0);
    check_final("golden", 0, 1'b1);
`ifdef SIMPLE_STIM_CHK_CAPTURE_EN
    total++;
    if (first_err_idx !== '0 || first_err_exp !== 1'b0) begin
      bad++;
      $display("FAIL golden_capture idx=%0d exp_bit=%b exp 0 0", first_err_idx, first_err_exp);
    end
`endif
  endtask

  task automatic test_stuck();
    stuck = 1'b1;
    run_check(1'b0);
    check_final("stuck_fault", count_zero_compares(), 1'b0);
`ifdef SIMPLE_STIM_CHK_CAPTURE_EN
    total++;
    if (first_err_idx !== '0 || first_err_exp !== 1'b0) begin
      bad++;
      $display("FAIL stuck_capture idx=%0d exp_bit=%b exp 0 0", first_err_idx, first_err_exp);
    end
`endif
    stuck = 1'b0;
  endtask

  task automatic test_back_to_back();
    // restart from DONE after the stuck run: counters clear, sequence repeats
    run_check(1'b0);
    check_final("restart_from_done", 0, 1'b1);
  endtask

  task automatic test_handshake();
    run_check(1'b1);
    check_final("start_ignored_busy", 0, 1'b1);
  endtask

  task automatic test_saturation();
    int cyc = 0;
    @(negedge clk); sat_start = 1'b1;
    @(negedge clk); sat_start = 1'b0;
    while (sat_done !== 1'b1 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    total++;
    if (sat_done !== 1'b1) begin
      bad++;
      $display("FAIL sat_timeout done=%b after %0d cycles exp 1", sat_done, cyc);
    end
    total++;
    if (sat_err_cnt !== 4'hF || sat_pass !== 1'b0) begin
      bad++;
      $display("FAIL saturation err=%h pass=%b exp err=f pass=0", sat_err_cnt, sat_pass);
    end
  endtask

  task automatic test_reset_mid_run();
    stuck = 1'b1;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (7) @(negedge clk);
    total++;
    if (err_cnt === '0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL midrun_precheck err=%0d busy=%b exp err>0 busy=1", err_cnt, busy);
    end
    rst_n = 1'b0;
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || inp1 !== 1'b0 || inp2 !== 1'b0 || err_cnt !== '0 || vec_cnt !== '0) begin
      bad++;
      $display("FAIL reset_mid_run busy=%b done=%b inp=%b%b err=%0d vec=%0d exp all 0",
               busy, done, inp2, inp1, err_cnt, vec_cnt);
    end
    rst_n = 1'b1;
    stuck = 1'b0;
    run_check(1'b0);
    check_final("after_reset_golden", 0, 1'b1);
  endtask

  initial begin
    build_model(N);
    test_reset();
    test_golden();
    test_stuck();
    test_back_to_back();
    test_handshake();
    test_saturation();
    test_reset_mid_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/simple_stim_chk.md
# simple_stim_chk

Self-checking stimulus/response companion for the `simple` timing benchmark. It drives the benchmark's two primary inputs with an LFSR pattern and receives its single primary output. Each returned value is compared against an internal cycle-accurate model of the benchmark's NAND/NOR/DFF loop. It sits beside the benchmark netlist in gate-level simulation and silicon-correlation harnesses, on the same clock.

## Interface
- `NUM_VECTORS`, 256: random vectors applied per run (≥1).
- `LFSR_SEED`, 16'hACE1: LFSR load value; 0 is replaced by 16'h0001.
- `CNT_W`, 16: width of the vector and error counters.

Ports:
- `tau2015_clk` in 1: single clock, rising edge.
- `tau2015_rst_n` in 1: reset, synchronous, active-low.
- `start` in 1: begin a run; sampled in IDLE or DONE only.
- `inp1` out 1: drive to benchmark `inp1`; registered.
- `inp2` out 1: drive to benchmark `inp2`; registered.
- `dut_out` in 1: from benchmark `out`.
- `busy` out 1: high in INIT/RUN/DRAIN.
- `done` out 1: high in DONE.
- `pass` out 1: valid when `done`; 1 iff `err_cnt`==0.
- `err_cnt` out CNT_W: saturating mismatch count.
- `vec_cnt` out CNT_W: vectors applied this run.

## Operation
- Model register `m` tracks benchmark flop `f1`: on every edge in INIT/RUN, `m <= inp1 & inp2 & ~m`.
- The benchmark flop has no reset. INIT drives 0/0 for 2 cycles, which forces `f1`=0 and `m`=0 without needing a reset on the benchmark.
- States:
  - IDLE: when `start`, go to INIT. Clear `err_cnt`, `vec_cnt`, `m`. Load the LFSR.
  - INIT: drive `inp1`=`inp2`=0 for 2 cycles, then go to RUN.
  - RUN: each cycle, present `inp1`=lfsr[0], `inp2`=lfsr[1], advance the LFSR, and increment `vec_cnt`. After NUM_VECTORS cycles, go to DRAIN.
  - DRAIN: drive 0/0. Perform one final compare, then go to DONE.
  - DONE: hold all results. On `start`, re-enter INIT with everything cleared.
- LFSR: 16-bit Fibonacci with taps 16,14,13,11, shifting toward bit 0.
- Compare: at every edge in RUN and DRAIN, if `dut_out != m` then `err_cnt` increments, saturating at all-ones. A run makes NUM_VECTORS+1 compares.
- `start` is ignored while `busy`.
- `inp1`/`inp2` are 0 in IDLE, INIT and DRAIN. In DONE they hold the last value driven by DRAIN (0/0).

## Timing
- Reset values: `inp1`=0, `inp2`=0, `busy`=0, `done`=0, `pass`=0, `err_cnt`=0, `vec_cnt`=0, `m`=0. The state goes to IDLE, and the LFSR reloads `LFSR_SEED`.
- Reset asserted mid-run: the block is in IDLE after that edge, and all outputs take their reset values. The partial run is discarded.
- Run latency: with `start` sampled at edge E0:
  - `busy`=1 after E0.
  - First RUN vector appears after E2.
  - Last RUN edge is E(2+N).
  - DRAIN compare happens at E(3+N).
  - `done`=1 after E(3+N).
  - Total is N+3 edges.
- `dut_out` is sampled with zero added latency: benchmark out = `f1`, which is combinational from the register.
- `pass` is updated together with `done` and cleared on restart.

## Configuration
- `SIMPLE_STIM_CHK_CAPTURE_EN` defined: adds two outputs.
  - `first_err_idx` (CNT_W): index of the first failing compare, where 0 is the first RUN edge and N is the DRAIN compare.
  - `first_err_exp` (1): `m` at that compare.
  - Both capture once per run, reset to 0, and clear on `start`.
- Macro undefined: these ports and registers are absent. All other behaviour is identical.

## Structure
- `simple_stim_chk_pkg` contains:
  - the state enum (IDLE, INIT, RUN, DRAIN, DONE);
  - `INIT_CYCLES`=2;
  - the LFSR tap mask constant 16'hB400;
  - the default seed.
- Sub-module `simple_stim_chk_lfsr` has load, advance and state outputs. The FSM, model and counters stay in the top.

## Test plan
- Reset: hold `tau2015_rst_n`=0 for 3 cycles with `start`=1 -> `inp1`=`inp2`=0, `busy`=0, `done`=0, `err_cnt`=0.
- Golden loop: NUM_VECTORS=16, behavioural `simple` connected, pulse `start` -> `done` rises exactly 19 edges later, `pass`=1, `err_cnt`=0, `vec_cnt`=16.
- Stuck fault: NUM_VECTORS=16, `dut_out` tied 1 -> `err_cnt` equals the number of the 17 model values equal to 0 (≥1, since the first compare expects 0), `pass`=0. With CAPTURE_EN: `first_err_idx`=0, `first_err_exp`=0.
- Saturation: CNT_W=4, NUM_VECTORS=32, `dut_out` = ~`m` -> `err_cnt`=4'hF, `pass`=0.
- Handshake: `start` pulsed at RUN vector 3 -> ignored, no restart. `start` in DONE -> `err_cnt`, `vec_cnt` and `done` clear, and the vector sequence repeats identically.
- Reset mid-run: drop `tau2015_rst_n` at RUN vector 5 -> IDLE after that edge, `inp1`/`inp2`=0, `busy`=0. A new `start` reproduces the golden sequence from the seed.
